huff_symbol_counter: RTL
========================

Name: huff_symbol_counter

Overview:
Front stage of the Huffman coding datapath, directly upstream of the merge/split controller and sorter. Consumes the gray-level sample stream (symbols 1..6) while gray_valid is high. Builds a per-symbol occurrence histogram CNT1..CNT6. Presents the final counts with a one-cycle CNT_valid pulse once the stream ends.

Parameters:
DATA_W, 8, width of gray_data
CNT_W, 8, width of each symbol count; counts saturate at 2^CNT_W-1
EXP_TOTAL, 100, expected samples per frame (used only with TOTAL_CHECK_EN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
gray_valid  input  1  high while gray_data carries a valid sample; one sample per cycle
gray_data  input  DATA_W  symbol value; legal values 1..6
CNT1..CNT6  output  CNT_W each  occurrence count of symbol 1..6; registered
CNT_valid  output  1  one-cycle pulse; CNT1..CNT6 are final while high
busy  output  1  high in COUNT and OUT states
sym_err  output  1  sticky per frame; set when a sample outside 1..6 is received
tot_cnt  output  CNT_W  total accepted samples (TOTAL_CHECK_EN only)
tot_err  output  1  total != EXP_TOTAL at frame end (TOTAL_CHECK_EN only)

Behaviour:
- Single clock clk. Reset is synchronous and active-high on port reset; it is sampled only on the rising edge of clk.
- Reset values: state=IDLE, CNT1..CNT6=0, CNT_valid=0, busy=0, sym_err=0, tot_cnt=0, tot_err=0.
- FSM states: IDLE, COUNT, OUT.
- IDLE: counts hold their last values.
  - gray_valid=1 starts a new frame: all counts and sym_err are cleared, the current sample is counted in the same edge, and the FSM goes to COUNT.
  - The first sample is never lost.
- COUNT:
  - Each edge with gray_valid=1: CNTk += 1, where k = gray_data, if 1 <= gray_data <= 6.
  - Otherwise no count changes and sym_err is set to 1.
  - First edge with gray_valid=0: go to OUT and register CNT_valid=1.
- OUT: lasts exactly one cycle. CNT_valid=1 and counts are stable during it.
  - Next state is IDLE if gray_valid=0.
  - If gray_valid=1 in OUT, that sample starts a new frame exactly as from IDLE (clear + count, go to COUNT). CNT_valid still drops after this cycle.
- Latency: CNT_valid rises in the cycle after the first low gray_valid is sampled in COUNT. Total frame latency = N samples + 1 cycle.
- Saturation: a count at 2^CNT_W-1 stays there on further hits. Saturation does not set sym_err.
- Only one count changes per cycle. No two-symbol conflicts can occur.
- gray_valid gaps inside a frame are not supported: any low cycle ends the frame.
- Reset during COUNT or OUT aborts the frame.
  - No CNT_valid is produced.
  - All outputs return to their reset values on that edge.

Optional Feature:
TOTAL_CHECK_EN
- Defined:
  - Adds an accepted-sample counter tot_cnt. It is cleared at frame start, increments on every valid sample (legal or not), and saturates.
  - Adds tot_err, registered together with CNT_valid: 1 if tot_cnt != EXP_TOTAL. It holds until the next frame start.
- Undefined: tot_cnt, tot_err and the counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package / defines file, shared with the controller and sorter: state encodings (IDLE, COUNT, OUT), NUM_SYM=6, CNT_W default, legal symbol range.
- One sub-module: huff_sat_counter, a CNT_W saturating counter with sync clear and increment enable. It is instantiated six times (seven with TOTAL_CHECK_EN).

Test Plan:
- 100-sample frame with distribution 1:20, 2:15, 3:25, 4:10, 5:18, 6:12, then gray_valid=0.
  - CNT_valid pulses for exactly 1 cycle, 1 cycle after the low sample.
  - CNT1..6 = 20,15,25,10,18,12; sym_err=0; tot_err=0 with TOTAL_CHECK_EN.
- 300 consecutive samples of symbol 3 (CNT_W=8) -> CNT3=255 (saturated), other counts 0, sym_err=0.
- Frame of 10 samples with gray_data=0 at sample 4 and 7 at sample 8 -> those two are uncounted, sym_err=1, remaining counts sum to 8.
  - With TOTAL_CHECK_EN: tot_cnt=10 and tot_err=1.
- Frame A (5 samples of symbol 1), gray_valid low 1 cycle, then frame B starting in the OUT cycle (3 samples of symbol 2).
  - Frame A: CNT_valid with CNT1=5.
  - Frame B: CNT_valid with CNT1=0, CNT2=3; first B sample is counted.
- Reset asserted for 1 cycle after sample 50 of a 100-sample frame -> all outputs 0 the next cycle, no CNT_valid.
  - A subsequent full frame counts correctly from zero.
- Single-sample frame (symbol 6, one cycle) -> CNT6=1, other counts 0, CNT_valid 2 cycles after the sample edge.

Source files
------------

// File: rtl/huff_symbol_counter_pkg.sv
// Shared definitions for the Huffman front end, controller and sorter:
// FSM state encodings, symbol alphabet size, default count width and
// the legal symbol range with a helper to test it.
package huff_symbol_counter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      OUT   = 2'd2
   } state_t;

   localparam int unsigned NUM_SYM   = 6;
   localparam int unsigned CNT_W_DEF = 8;
   localparam int unsigned SYM_MIN   = 1;
   localparam int unsigned SYM_MAX   = 6;

   // True when v is a symbol the histogram can record.
   function automatic logic is_legal_sym(input logic [31:0] v);
      return (v >= 32'(SYM_MIN)) && (v <= 32'(SYM_MAX));
   endfunction

endpackage

// File: rtl/huff_symbol_counter_if.sv
// Gray-level sample stream: one sample per cycle while gray_valid is high.
// master drives the stream, slave (the symbol counter) consumes it.
interface huff_symbol_counter_if #(
   parameter int DATA_W = 8
);
   logic              gray_valid;
   logic [DATA_W-1:0] gray_data;

   modport master (output gray_valid, output gray_data);
   modport slave  (input  gray_valid, input  gray_data);
endinterface

// File: rtl/huff_sat_counter.sv
// W-bit saturating counter with synchronous clear and increment enable.
// Clear and increment on the same edge load 1, so a frame's first sample
// is counted on the edge that clears the previous frame.
module huff_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);
   localparam logic [W-1:0] MAX_VAL = '1;

   logic [W-1:0] count_reg;

   // Clear has priority; otherwise count up and stick at full scale.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= inc ? W'(1) : '0;
      end else if (inc && (count_reg != MAX_VAL)) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign count = count_reg;
endmodule

// File: rtl/huff_symbol_counter.sv
// Symbol histogram front stage of the Huffman datapath.
// Counts symbols 1..6 over a contiguous gray_valid burst and pulses
// CNT_valid for one cycle after the burst ends.
// Optional build macro TOTAL_CHECK_EN adds a total-sample counter
// (tot_cnt) and a frame-length mismatch flag (tot_err).
module huff_symbol_counter
   import huff_symbol_counter_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int EXP_TOTAL = 100
) (
   input  logic                 clk,
   input  logic                 reset,
   huff_symbol_counter_if.slave gray,
   output logic [CNT_W-1:0]     CNT1,
   output logic [CNT_W-1:0]     CNT2,
   output logic [CNT_W-1:0]     CNT3,
   output logic [CNT_W-1:0]     CNT4,
   output logic [CNT_W-1:0]     CNT5,
   output logic [CNT_W-1:0]     CNT6,
   output logic                 CNT_valid,
   output logic                 busy,
`ifdef TOTAL_CHECK_EN
   output logic [CNT_W-1:0]     tot_cnt,
   output logic                 tot_err,
`endif
   output logic                 sym_err
);

   state_t            state_reg;
   logic              cnt_valid_reg;
   logic              busy_reg;
   logic              sym_err_reg;
   logic              legal;
   logic              start_frame;
   logic [CNT_W-1:0]  cnt_q [NUM_SYM];

   // A valid sample outside COUNT (i.e. in IDLE or OUT) opens a new frame.
   assign legal       = is_legal_sym(32'(gray.gray_data));
   assign start_frame = gray.gray_valid && (state_reg != COUNT);

   // One saturating counter per symbol; at most one hit per cycle.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SYM; gi++) begin : g_sym
         logic hit;
         assign hit = gray.gray_valid &&
                      (gray.gray_data == DATA_W'(gi + SYM_MIN));
         huff_sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (start_frame),
            .inc   (hit),
            .count (cnt_q[gi])
         );
      end
   endgenerate

`ifdef TOTAL_CHECK_EN
   logic tot_err_reg;

   // Every valid sample counts towards the frame length, legal or not.
   huff_sat_counter #(.W(CNT_W)) u_tot (
      .clk   (clk),
      .reset (reset),
      .clr   (start_frame),
      .inc   (gray.gray_valid),
      .count (tot_cnt)
   );
   assign tot_err = tot_err_reg;
`endif

   // Frame FSM with registered CNT_valid, busy and sticky sym_err.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         cnt_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         sym_err_reg   <= 1'b0;
`ifdef TOTAL_CHECK_EN
         tot_err_reg   <= 1'b0;
`endif
      end else begin
         cnt_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (gray.gray_valid) begin
                  state_reg <= COUNT;
                  busy_reg  <= 1'b1;
               end
            end
            COUNT: begin
               if (!gray.gray_valid) begin
                  state_reg     <= OUT;
                  cnt_valid_reg <= 1'b1;
`ifdef TOTAL_CHECK_EN
                  tot_err_reg   <= (tot_cnt != CNT_W'(EXP_TOTAL));
`endif
               end
            end
            OUT: begin
               if (gray.gray_valid) begin
                  state_reg <= COUNT;
               end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase

         // sym_err restarts with the new frame's first sample.
         if (start_frame) begin
            sym_err_reg <= !legal;
`ifdef TOTAL_CHECK_EN
            tot_err_reg <= 1'b0;
`endif
         end else if (gray.gray_valid && !legal) begin
            sym_err_reg <= 1'b1;
         end
      end
   end

   assign CNT1      = cnt_q[0];
   assign CNT2      = cnt_q[1];
   assign CNT3      = cnt_q[2];
   assign CNT4      = cnt_q[3];
   assign CNT5      = cnt_q[4];
   assign CNT6      = cnt_q[5];
   assign CNT_valid = cnt_valid_reg;
   assign busy      = busy_reg;
   assign sym_err   = sym_err_reg;

endmodule
